assembler: RTL and testbench

ASSEMBLER -- requirements
Module: assembler

---
 rtl/assembler.sv | 106 ++++++++++
 tb/tb_assembler.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/assembler.sv
// Serialises a solved puzzle grid into UART bytes, two per row, under a send/transmit_done handshake.
// Optional macro ASSEMBLER_HEADER_EN prepends one {m[3:0], n[3:0]} header byte.
module assembler #(
    parameter int MAX_ROWS = 11,
    parameter int MAX_COLS = 11
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          valid_in,
    input  logic                          transmit_done,
    input  logic [MAX_ROWS*MAX_COLS-1:0]  solution,
    input  logic [$clog2(MAX_COLS)-1:0]   n,
    input  logic [$clog2(MAX_ROWS)-1:0]   m,
    output logic                          send,
    output logic [7:0]                    byte_out,
    output logic                          done
);

    localparam int CELLS = MAX_ROWS * MAX_COLS;
    localparam int NW    = $clog2(MAX_COLS);
    localparam int CW    = $clog2(2 * MAX_ROWS + 2) + 1;
`ifdef ASSEMBLER_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SEND   = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;

    logic [1:0]       state;
    logic [CELLS-1:0] sol_q;
    logic [NW-1:0]    n_q;
    logic [CW-1:0]    idx;
    logic [CW-1:0]    total;
    logic [CW-1:0]    nxt;
    logic [CW-1:0]    tot_in;
    logic             empty_in;

    // Row byte b of the grid: even b is the high byte {5'b0, w[10:8]}, odd b is w[7:0].
    function automatic logic [7:0] row_byte(input logic [CELLS-1:0] g,
                                            input logic [NW-1:0] nn,
                                            input logic [CW-1:0] b);
        logic [10:0] w;
        int          base;
        w    = '0;
        base = int'(b >> 1) * MAX_COLS;
        for (int c = 0; c < 11; c++)
            if (c < MAX_COLS && c < int'(nn) && base + c < CELLS)
                w[c] = g[base + c];
        return b[0] ? w[7:0] : {5'b0, w[10:8]};
    endfunction

    always_comb begin
        empty_in = (m == '0) || (n == '0) || (int'(m) > MAX_ROWS) || (int'(n) > MAX_COLS);
        tot_in   = empty_in ? CW'(HDR) : CW'(2 * int'(m) + HDR);
        nxt      = idx + CW'(1);
    end

    assign send = (state == SEND);
    assign done = (state == FINISH);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            sol_q    <= '0;
            n_q      <= '0;
            idx      <= '0;
            total    <= '0;
            byte_out <= 8'h00;
        end else begin
            case (state)
                IDLE: if (valid_in) begin
                    sol_q <= solution;
                    n_q   <= n;
                    idx   <= '0;
                    total <= tot_in;
                    if (tot_in == '0) begin
                        state <= FINISH;
                    end else begin
                        state <= SEND;
`ifdef ASSEMBLER_HEADER_EN
                        byte_out <= {4'(m), 4'(n)};
`else
                        byte_out <= row_byte(solution, n, '0);
`endif
                    end
                end
                SEND: state <= WAIT;
                WAIT: if (transmit_done) begin
                    if (nxt < total) begin
                        idx      <= nxt;
                        byte_out <= row_byte(sol_q, n_q, nxt - CW'(HDR));
                        state    <= SEND;
                    end else begin
                        state <= FINISH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_assembler.sv
// Randomised bench for assembler: expected byte streams come from a row-by-row reference model.
module tb_assembler;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         valid_in = 1'b0;
    logic         transmit_done = 1'b0;
    logic [120:0] solution = '0;
    logic [3:0]   n = '0;
    logic [3:0]   m = '0;
    logic         send;
    logic [7:0]   byte_out;
    logic         done;

    int checks = 0;
    int errors = 0;

    assembler #(.MAX_ROWS(11), .MAX_COLS(11)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .transmit_done(transmit_done),
        .solution(solution), .n(n), .m(m),
        .send(send), .byte_out(byte_out), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [120:0] rnd_grid();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[120:0];
    endfunction

    // Reference byte stream straight from the row/column rules.
    task automatic model(input logic [120:0] g, input int mm, input int nn, output logic [7:0] q[$]);
        int w;
        q = {};
`ifdef ASSEMBLER_HEADER_EN
        q.push_back(8'((mm % 16) * 16 + (nn % 16)));
`endif
        if (mm >= 1 && nn >= 1 && mm <= 11 && nn <= 11)
            for (int r = 0; r < mm; r++) begin
                w = 0;
                for (int c = 0; c < nn; c++)
                    if (g[r * 11 + c]) w += (1 << c);
                q.push_back(8'(w / 256));
                q.push_back(8'(w % 256));
            end
    endtask

    task automatic run(input logic [120:0] g, input int mm, input int nn, input bit glitch);
        logic [7:0] q[$];
        int gaps;
        model(g, mm, nn, q);
        solution = g; m = 4'(mm); n = 4'(nn); valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        solution = rnd_grid(); m = 4'($urandom); n = 4'($urandom);
        foreach (q[i]) begin
            check("send", send, 1);
            check("byte", byte_out, q[i]);
            check("done_early", done, 0);
            if (glitch) transmit_done = 1'b1;
            @(negedge clk);
            transmit_done = 1'b0;
            check("wait_send", send, 0);
            gaps = $urandom_range(0, 3);
            repeat (gaps) begin
                if (glitch) valid_in = 1'b1;
                @(negedge clk);
                valid_in = 1'b0;
                check("gap_send", send, 0);
                check("gap_hold", byte_out, q[i]);
                check("gap_done", done, 0);
            end
            transmit_done = 1'b1;
            @(negedge clk);
            transmit_done = 1'b0;
        end
        check("done", done, 1);
        check("done_send", send, 0);
        if (glitch) valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        check("done_pulse", done, 0);
        check("idle_send", send, 0);
        @(negedge clk);
        check("idle_after", send | done, 0);
    endtask

    initial begin
        logic [120:0] g;
        logic [7:0]   q[$];

        repeat (2) @(negedge clk);
        check("rst_send", send, 0);
        check("rst_done", done, 0);
        check("rst_byte", byte_out, 0);
        rst = 1'b1;
        @(negedge clk);

        g = '0; g[0] = 1'b1;
        run(g, 1, 1, 0);
        g = '0; g[10:0] = '1;
        run(g, 2, 11, 0);
        run(g, 1, 5, 0);
        run(g, 3, 5, 0);
        run(rnd_grid(), 4, 7, 1);
        run(rnd_grid(), 11, 11, 1);
        run(rnd_grid(), 0, 5, 0);
        run(rnd_grid(), 3, 0, 0);
        run(rnd_grid(), 12, 4, 0);
        run(rnd_grid(), 2, 12, 1);

        // Reset after the second byte of a 3-row grid, then restart from row 0.
        g = rnd_grid();
        model(g, 3, 11, q);
        solution = g; m = 4'd3; n = 4'd11; valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        check("r_b0", byte_out, q[0]);
        @(negedge clk);
        transmit_done = 1'b1;
        @(negedge clk);
        transmit_done = 1'b0;
        check("r_send1", send, 1);
        check("r_b1", byte_out, q[1]);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("r_clr_send", send, 0);
        check("r_clr_done", done, 0);
        check("r_clr_byte", byte_out, 0);
        rst = 1'b1;
        transmit_done = 1'b1;
        @(negedge clk);
        transmit_done = 1'b0;
        repeat (3) begin
            check("r_quiet", send | done, 0);
            @(negedge clk);
        end
        run(g, 3, 11, 0);

        for (int i = 0; i < 30; i++)
            run(rnd_grid(), int'($urandom_range(0, 12)), int'($urandom_range(0, 12)), bit'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
